// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the core LSU and a debug/DMA port share one
// memory bus. There is one outstanding access at a time, with tie fairness and a bounded wait.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic        i_c_req,
  input  logic        i_c_we,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  input  logic [2:0]  i_c_nbyte,
  output logic        o_c_ack,
  output logic        o_c_err,
  output logic [31:0] o_c_rdata,
  output logic        o_c_stall,

  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [2:0]  i_d_nbyte,
  output logic        o_d_ack,
  output logic        o_d_err,
  output logic [31:0] o_d_rdata,

  output logic        o_m_req,
  output logic        o_m_we,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  output logic [2:0]  o_m_nbyte,
  input  logic        i_m_ack,
  input  logic [31:0] i_m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  // The counter equals the number of BUSY cycles already completed.
  // The timeout fires during the TIMEOUT-th BUSY cycle.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic        owner_q;
  logic        last_q;
  logic        err_q;
  logic [7:0]  cnt_q;
  logic        lat_we_q;
  logic [31:0] lat_addr_q;
  logic [31:0] lat_wdata_q;
  logic [2:0]  lat_nbyte_q;
  logic [31:0] c_rdata_q;
  logic [31:0] d_rdata_q;

  logic        grant;
  logic        grant_port;
  logic        timeout_hit;

  // When both ports request together, the grant goes to the port that did not win last time.
  always_comb begin
    grant      = 1'b0;
    grant_port = PORT_CORE;
    if (state_q == IDLE) begin
      if (i_c_req && i_d_req) begin
        grant      = 1'b1;
        grant_port = ~last_q;
      end else if (i_c_req) begin
        grant      = 1'b1;
        grant_port = PORT_CORE;
      end else if (i_d_req) begin
        grant      = 1'b1;
        grant_port = PORT_DBG;
      end
    end
  end

  assign timeout_hit = (state_q == BUSY) && !i_m_ack && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY:    if (i_m_ack || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      owner_q     <= PORT_CORE;
      last_q      <= PORT_DBG;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 32'd0;
      lat_nbyte_q <= 3'd0;
      c_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      if (grant) begin
        owner_q     <= grant_port;
        last_q      <= grant_port;
        lat_we_q    <= (grant_port == PORT_DBG) ? i_d_we    : i_c_we;
        lat_addr_q  <= (grant_port == PORT_DBG) ? i_d_addr  : i_c_addr;
        lat_wdata_q <= (grant_port == PORT_DBG) ? i_d_wdata : i_c_wdata;
        lat_nbyte_q <= (grant_port == PORT_DBG) ? i_d_nbyte : i_c_nbyte;
      end
      case (state_q)
        BUSY: begin
          cnt_q <= cnt_q + 8'd1;
          if (i_m_ack) begin
            err_q <= 1'b0;
            if (!lat_we_q) begin
              if (owner_q == PORT_DBG) d_rdata_q <= i_m_rdata;
              else                     c_rdata_q <= i_m_rdata;
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            if (owner_q == PORT_DBG) d_rdata_q <= 32'd0;
            else                     c_rdata_q <= 32'd0;
          end
        end
        RESP: begin
          cnt_q <= 8'd0;
          err_q <= 1'b0;
        end
        default: cnt_q <= 8'd0;
      endcase
    end
  end

  assign o_m_req   = (state_q == BUSY);
  assign o_m_we    = (state_q == BUSY) && lat_we_q;
  assign o_m_addr  = lat_addr_q;
  assign o_m_wdata = lat_wdata_q;
  assign o_m_nbyte = lat_nbyte_q;

  assign o_c_ack   = (state_q == RESP) && (owner_q == PORT_CORE);
  assign o_d_ack   = (state_q == RESP) && (owner_q == PORT_DBG);
  assign o_c_err   = o_c_ack && err_q;
  assign o_d_err   = o_d_ack && err_q;
  assign o_c_rdata = c_rdata_q;
  assign o_d_rdata = d_rdata_q;
  assign o_c_stall = i_c_req && !o_c_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: it pushes expected completions into a queue when a request
// is issued and checks them against the response cycle.
module tb_dmem_arbiter;

  localparam int TIMEOUT = 15;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_c_req, i_c_we;
  logic [31:0] i_c_addr, i_c_wdata;
  logic [2:0]  i_c_nbyte;
  logic        o_c_ack, o_c_err, o_c_stall;
  logic [31:0] o_c_rdata;
  logic        i_d_req, i_d_we;
  logic [31:0] i_d_addr, i_d_wdata;
  logic [2:0]  i_d_nbyte;
  logic        o_d_ack, o_d_err;
  logic [31:0] o_d_rdata;
  logic        o_m_req, o_m_we;
  logic [31:0] o_m_addr, o_m_wdata;
  logic [2:0]  o_m_nbyte;
  logic        i_m_ack;
  logic [31:0] i_m_rdata;

  typedef struct {
    logic        owner;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] c_model;
  logic [31:0] d_model;
  int          checks = 0;
  int          fails  = 0;

  dmem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_c_req(i_c_req), .i_c_we(i_c_we), .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata),
    .i_c_nbyte(i_c_nbyte), .o_c_ack(o_c_ack), .o_c_err(o_c_err), .o_c_rdata(o_c_rdata),
    .o_c_stall(o_c_stall),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .i_d_nbyte(i_d_nbyte), .o_d_ack(o_d_ack), .o_d_err(o_d_err), .o_d_rdata(o_d_rdata),
    .o_m_req(o_m_req), .o_m_we(o_m_we), .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata),
    .o_m_nbyte(o_m_nbyte), .i_m_ack(i_m_ack), .i_m_rdata(i_m_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] nb);
    if (port) begin
      i_d_req = req; i_d_we = we; i_d_addr = addr; i_d_wdata = wdata; i_d_nbyte = nb;
    end else begin
      i_c_req = req; i_c_we = we; i_c_addr = addr; i_c_wdata = wdata; i_c_nbyte = nb;
    end
  endtask

  task automatic drop_requests();
    i_c_req = 1'b0;
    i_d_req = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    checkOutput({tag, "_flags"}, {28'd0, o_c_ack, o_d_ack, o_c_err, o_d_err}, 32'd0);
    checkOutput({tag, "_mreq"}, {31'd0, o_m_req}, 32'd0);
    checkOutput({tag, "_c_rdata"}, o_c_rdata, c_model);
    checkOutput({tag, "_d_rdata"}, o_d_rdata, d_model);
  endtask

  // The response cycle pops the oldest expectation and compares flags and data on both ports.
  task automatic observe();
    exp_t       e;
    logic [3:0] exp_flags;
    checkOutput("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      exp_flags = e.owner ? {1'b0, 1'b1, 1'b0, e.err} : {1'b1, 1'b0, e.err, 1'b0};
      checkOutput("resp_flags", {28'd0, o_c_ack, o_d_ack, o_c_err, o_d_err}, {28'd0, exp_flags});
      checkOutput("owner_rdata", e.owner ? o_d_rdata : o_c_rdata, e.rdata);
      checkOutput("other_rdata", e.owner ? o_c_rdata : o_d_rdata, e.owner ? c_model : d_model);
    end
  endtask

  task automatic run_txn(input logic both, input logic port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] nb, input int ack_cycle,
                         input logic [31:0] mem_data, input logic drop_early);
    exp_t e;
    int   busy_len;
    e.owner = port;
    e.err   = !(ack_cycle >= 1 && ack_cycle <= TIMEOUT);
    e.rdata = e.err ? 32'd0 : (we ? (port ? d_model : c_model) : mem_data);
    if (port) d_model = e.rdata;
    else      c_model = e.rdata;
    sb.push_back(e);
    busy_len = e.err ? TIMEOUT : ack_cycle;

    applyStimulus(port, 1'b1, we, addr, wdata, nb);
    if (both) applyStimulus(~port, 1'b1, ~we, ~addr, ~wdata, ~nb);
    #1;
    if (!port) checkOutput("stall_req", {31'd0, o_c_stall}, 32'd1);
    tick();
    for (int k = 1; k <= busy_len; k++) begin
      checkOutput("m_req_busy", {31'd0, o_m_req}, 32'd1);
      checkOutput("no_ack_busy", {28'd0, o_c_ack, o_d_ack, o_c_err, o_d_err}, 32'd0);
      if (k == 1) begin
        checkOutput("m_addr", o_m_addr, addr);
        checkOutput("m_wdata", o_m_wdata, wdata);
        checkOutput("m_we_nbyte", {28'd0, o_m_we, o_m_nbyte}, {28'd0, we, nb});
        if (!port) checkOutput("stall_busy", {31'd0, o_c_stall}, 32'd1);
        if (drop_early) drop_requests();
      end
      if (k == ack_cycle) begin
        i_m_ack   = 1'b1;
        i_m_rdata = mem_data;
      end
      tick();
      i_m_ack   = 1'b0;
      i_m_rdata = 32'h0BAD_F00D;
    end
    checkOutput("m_req_resp", {31'd0, o_m_req}, 32'd0);
    if (!port && !drop_early) checkOutput("stall_resp", {31'd0, o_c_stall}, 32'd0);
    observe();
    tick();
    drop_requests();
    #1;
    check_quiet("after_resp");
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_m_ack = 1'b0;
    i_m_rdata = 32'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    c_model = 32'd0;
    d_model = 32'd0;
    tick();
    tick();
    check_quiet("reset");
    checkOutput("reset_mbus", o_m_addr | o_m_wdata | {29'd0, o_m_nbyte} | {31'd0, o_m_we}, 32'd0);
    i_rst_n = 1'b1;
    tick();

    // Stray memory ack while idle
    i_m_ack = 1'b1; i_m_rdata = 32'hFFFF_FFFF;
    tick();
    i_m_ack = 1'b0;
    check_quiet("idle_ack");
    tick();
    check_quiet("idle_ack2");

    // Three simultaneous requests: core, debug, core
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h1111_1111, 3'd4, 2, 32'hA000_0001, 1'b0);
    run_txn(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h2222_2222, 3'd2, 2, 32'hA000_0002, 1'b0);
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h3333_3333, 3'd1, 2, 32'hA000_0003, 1'b0);

    // Minimum latency core read
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 3'd4, 1, 32'hDEAD_BEEF, 1'b0);
    // Debug write that never gets an ack
    run_txn(1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h55AA_55AA, 3'd4, 0, 32'h0, 1'b0);
    // Ack on the final BUSY cycle wins over the timeout
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 3'd4, TIMEOUT, 32'hCAFE_F00D, 1'b0);
    // Debug write whose request drops mid-BUSY; read data must stay put
    run_txn(1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h1234_5678, 3'd2, 3, 32'h9999_9999, 1'b1);

    // Reset mid-BUSY followed by a late memory ack
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'd4);
    tick();
    tick();
    checkOutput("pre_reset_busy", {31'd0, o_m_req}, 32'd1);
    tick();
    i_rst_n = 1'b0;
    drop_requests();
    tick();
    i_rst_n = 1'b1;
    c_model = 32'd0;
    d_model = 32'd0;
    check_quiet("mid_reset");
    checkOutput("mid_reset_mbus", o_m_addr | o_m_wdata | {29'd0, o_m_nbyte} | {31'd0, o_m_we}, 32'd0);
    i_m_ack = 1'b1; i_m_rdata = 32'h1234_ABCD;
    tick();
    i_m_ack = 1'b0;
    check_quiet("late_ack");
    tick();
    check_quiet("late_ack2");

    // The pointer is back at debug, so the core wins the next tie
    run_txn(1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 3'd4, 1, 32'h7777_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles in BUSY awaiting i_m_ack before abort (range 1..255).
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_c_req, i_c_we  in  1,1  core LSU request / write-enable.
REQ-005 i_c_addr, i_c_wdata  in  32,32  core address / store data.
REQ-006 i_c_nbyte  in  3  core access-size code, passed through unchecked.
REQ-007 o_c_ack, o_c_err  out  1,1  core completion pulse / timeout-error pulse.
REQ-008 o_c_rdata  out  32  core load data.
REQ-009 o_c_stall  out  1  core stall = i_c_req & ~o_c_ack (combinational).
REQ-010 i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_nbyte, o_d_ack, o_d_err, o_d_rdata: debug/DMA port, same widths and meaning as core port.
REQ-011 o_m_req, o_m_we  out  1,1  memory request / write-enable.
REQ-012 o_m_addr, o_m_wdata  out  32,32  memory address / store data.
REQ-013 o_m_nbyte  out  3  memory access-size code.
REQ-014 i_m_ack  in  1  memory completion, one-cycle pulse.
REQ-015 i_m_rdata  in  32  memory read data, valid with i_m_ack.

Function
REQ-016 FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-017 IDLE: no request -> stay; any request -> latch winner's we/addr/wdata/nbyte, record owner, go BUSY.
REQ-018 Both requests in same IDLE cycle -> grant port not equal to last-granted pointer; pointer reset value = debug, so core wins first tie.
REQ-019 Last-granted pointer updates on every grant.
REQ-020 BUSY: o_m_req=1 with latched fields, stable until exit; cycle counter increments each BUSY cycle.
REQ-021 BUSY with i_m_ack=1 -> capture i_m_rdata into owner's rdata register if read (write leaves it unchanged), go RESP, o_m_req=0 next cycle.
REQ-022 BUSY counter reaches TIMEOUT without i_m_ack -> go RESP flagged error; owner's rdata register set to 0.
REQ-023 i_m_ack and timeout in same cycle -> ack wins, no error.
REQ-024 RESP: exactly one cycle; owner's o_x_ack=1, o_x_err=1 only if timed out; then IDLE, counter cleared.
REQ-025 Requests ignored in BUSY and RESP; requester holds request until ack, deasserts cycle after ack.
REQ-026 Request dropping during BUSY does not cancel transaction; ack still pulses.
REQ-027 i_m_ack outside BUSY ignored.
REQ-028 Minimum latency: request in IDLE cycle N -> o_m_req cycle N+1 -> ack at N+1 -> o_x_ack cycle N+2.
REQ-029 o_x_rdata holds value until next owned read completion or timeout.
REQ-030 Non-owner ack/err outputs remain 0 at all times.

Reset
REQ-031 i_rst_n=0 at rising edge, any state -> IDLE; o_m_req, o_m_we, o_c_ack, o_d_ack, o_c_err, o_d_err = 0; o_m_addr, o_m_wdata, o_m_nbyte, o_c_rdata, o_d_rdata = 0; counter 0; pointer = debug.
REQ-032 Reset mid-BUSY abandons transaction without ack or err; i_m_ack arriving after reset ignored.

Verification
REQ-033 Core read addr 0x100, memory acks next cycle with 0xDEADBEEF -> o_m_req one cycle, o_c_ack pulse cycle N+2, o_c_rdata=0xDEADBEEF, o_c_stall high cycles N..N+1.
REQ-034 Core and debug request same cycle, repeated three times -> grant order core, debug, core; no ack on wrong port.
REQ-035 Debug write 0x55AA55AA to 0x200, memory never acks, TIMEOUT=15 -> o_m_req high 15 cycles, o_d_ack=o_d_err=1 one cycle, o_d_rdata=0.
REQ-036 i_m_ack asserted exactly on 15th BUSY cycle -> o_c_ack=1, o_c_err=0, data captured.
REQ-037 i_rst_n=0 for one cycle mid-BUSY then late i_m_ack -> all outputs 0, state IDLE, no ack pulse.
REQ-038 i_m_ack pulsed while IDLE, no requests -> no output change.
